// File: rtl/vx_gpu_csr_file.sv
// Per-warp GPU CSR file: SCRATCH0/1 storage per lane, write counters, a free-running
// cycle counter and read-only id registers. Reads are combinational; writes land on the edge.
module vx_gpu_csr_file #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned NUM_THREADS   = 4,
  parameter int unsigned UUID_BITS     = 44,
  parameter int unsigned NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int unsigned CSR_ADDR_BITS = 12,
  parameter logic [CSR_ADDR_BITS-1:0] SCRATCH_BASE = 12'hCC0,
  parameter logic [CSR_ADDR_BITS-1:0] TID_ADDR     = 12'hCC4,
  parameter logic [CSR_ADDR_BITS-1:0] WID_ADDR     = 12'hCC5,
  parameter logic [CSR_ADDR_BITS-1:0] WRCNT_ADDR   = 12'hCC6,
  parameter logic [CSR_ADDR_BITS-1:0] CYCLE_ADDR   = 12'hCC8,
  parameter logic [CSR_ADDR_BITS-1:0] CYCLE_H_ADDR = 12'hCC9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read_enable,
  input  logic [UUID_BITS-1:0]          read_uuid,
  input  logic [NW_BITS-1:0]            read_wid,
  input  logic [NUM_THREADS-1:0]        read_tmask,
  input  logic [CSR_ADDR_BITS-1:0]      read_addr,
  output logic [NUM_THREADS-1:0][31:0]  read_data,
  input  logic                          write_enable,
  input  logic [UUID_BITS-1:0]          write_uuid,
  input  logic [NW_BITS-1:0]            write_wid,
  input  logic [NUM_THREADS-1:0]        write_tmask,
  input  logic [CSR_ADDR_BITS-1:0]      write_addr,
  input  logic [NUM_THREADS-1:0][31:0]  write_data,
  output logic                          illegal_write,
  output logic [UUID_BITS-1:0]          illegal_uuid
);

  localparam int unsigned WIDX_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned CNT_BITS  = 16;
  localparam logic [CSR_ADDR_BITS-1:0] SCRATCH1_ADDR = SCRATCH_BASE + CSR_ADDR_BITS'(1);

  logic [31:0]          scratch_mem [2][NUM_WARPS][NUM_THREADS];
  logic [CNT_BITS-1:0]  wrcnt [NUM_WARPS];
  logic [63:0]          cycle;

  logic                 rd_wid_ok;
  logic [WIDX_BITS-1:0] rd_idx;
  logic                 wr_wid_ok;
  logic                 wr_addr_ok;
  logic                 wr_accept;
  logic                 wr_reject;
  logic                 wr_sel;
  logic [WIDX_BITS-1:0] wr_idx;

  // uuids are debug tags; only the write uuid is ever captured
  logic unused_read_uuid;
  assign unused_read_uuid = ^read_uuid;

  assign rd_wid_ok  = 32'(read_wid) < NUM_WARPS;
  assign rd_idx     = WIDX_BITS'(read_wid);
  assign wr_wid_ok  = 32'(write_wid) < NUM_WARPS;
  assign wr_idx     = WIDX_BITS'(write_wid);
  assign wr_addr_ok = (write_addr == SCRATCH_BASE) || (write_addr == SCRATCH1_ADDR);
  assign wr_sel     = (write_addr == SCRATCH1_ADDR);
  assign wr_accept  = write_enable && wr_addr_ok && wr_wid_ok;
  assign wr_reject  = write_enable && !wr_accept;

  // Read decode: sees pre-edge state only, no write bypass
  always_comb begin
    read_data = '0;
    if (read_enable && rd_wid_ok) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (read_tmask[l]) begin
          case (read_addr)
            SCRATCH_BASE:  read_data[l] = scratch_mem[0][rd_idx][l];
            SCRATCH1_ADDR: read_data[l] = scratch_mem[1][rd_idx][l];
            TID_ADDR:      read_data[l] = 32'(l);
            WID_ADDR:      read_data[l] = 32'(read_wid);
            WRCNT_ADDR:    read_data[l] = {16'h0, wrcnt[rd_idx]};
            CYCLE_ADDR:    read_data[l] = cycle[31:0];
            CYCLE_H_ADDR:  read_data[l] = cycle[63:32];
            default:       read_data[l] = 32'h0;
          endcase
        end
      end
    end
  end

  // Scratch storage: lane-masked update on accepted writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
          scratch_mem[0][w][l] <= '0;
          scratch_mem[1][w][l] <= '0;
        end
      end
    end else if (wr_accept) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (write_tmask[l]) begin
          scratch_mem[wr_sel][wr_idx][l] <= write_data[l];
        end
      end
    end
  end

  // Per-warp accepted-write counters, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wrcnt[w] <= '0;
      end
    end else if (wr_accept && (wrcnt[wr_idx] != {CNT_BITS{1'b1}})) begin
      wrcnt[wr_idx] <= wrcnt[wr_idx] + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 64'd1;
    end
  end

  // Rejected-write reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_write <= 1'b0;
      illegal_uuid  <= '0;
    end else begin
      illegal_write <= wr_reject;
      if (wr_reject) begin
        illegal_uuid <= write_uuid;
      end
    end
  end

endmodule

// File: tb/tb_vx_gpu_csr_file.sv
// Bench for vx_gpu_csr_file: directed scenarios plus random traffic against a
// behavioural model of the CSR map (scratch words, write counts, elapsed cycles).
module tb_vx_gpu_csr_file;

  localparam int NW = 4;
  localparam int NT = 4;
  localparam int UB = 8;
  localparam int WB = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                read_enable;
  logic [UB-1:0]       read_uuid;
  logic [WB-1:0]       read_wid;
  logic [NT-1:0]       read_tmask;
  logic [11:0]         read_addr;
  logic [NT-1:0][31:0] read_data;
  logic                write_enable;
  logic [UB-1:0]       write_uuid;
  logic [WB-1:0]       write_wid;
  logic [NT-1:0]       write_tmask;
  logic [11:0]         write_addr;
  logic [NT-1:0][31:0] write_data;
  logic                illegal_write;
  logic [UB-1:0]       illegal_uuid;

  vx_gpu_csr_file #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .UUID_BITS(UB), .NW_BITS(WB)
  ) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid),
    .read_tmask(read_tmask), .read_addr(read_addr), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
    .write_tmask(write_tmask), .write_addr(write_addr), .write_data(write_data),
    .illegal_write(illegal_write), .illegal_uuid(illegal_uuid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [31:0]       m_scr [2][NW][NT];
  int unsigned       m_writes [NW];
  longint unsigned   m_cycles;
  logic              m_ill;
  logic [UB-1:0]     m_uuid;

  logic [11:0] addr_pool [9] = '{12'hCC0, 12'hCC1, 12'hCC4, 12'hCC5, 12'hCC6,
                                 12'hCC8, 12'hCC9, 12'hCC2, 12'h123};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0][31:0] exp_read();
    logic [NT-1:0][31:0] r;
    int w;
    int unsigned cnt;
    r = '0;
    w = int'(read_wid);
    if (!read_enable || w >= NW) return r;
    cnt = (m_writes[w] > 32'd65535) ? 32'd65535 : m_writes[w];
    for (int l = 0; l < NT; l++) begin
      if (read_tmask[l]) begin
        case (read_addr)
          12'hCC0: r[l] = m_scr[0][w][l];
          12'hCC1: r[l] = m_scr[1][w][l];
          12'hCC4: r[l] = 32'(l);
          12'hCC5: r[l] = 32'(w);
          12'hCC6: r[l] = cnt;
          12'hCC8: r[l] = m_cycles[31:0];
          12'hCC9: r[l] = m_cycles[63:32];
          default: r[l] = 32'h0;
        endcase
      end
    end
    return r;
  endfunction

  task automatic set_rd(input bit en, input logic [11:0] a, input int wid, input logic [NT-1:0] tm);
    read_enable = en;
    read_addr   = a;
    read_wid    = WB'(wid);
    read_tmask  = tm;
    read_uuid   = UB'($urandom);
  endtask

  task automatic set_wr(input bit en, input logic [11:0] a, input int wid, input logic [NT-1:0] tm,
                        input logic [NT-1:0][31:0] d, input logic [UB-1:0] u);
    write_enable = en;
    write_addr   = a;
    write_wid    = WB'(wid);
    write_tmask  = tm;
    write_data   = d;
    write_uuid   = u;
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic tick(input bit check_rd, input bit check_ill);
    int w;
    bit ok;
    #1;
    if (check_rd) chk("read_data", read_data, exp_read());
    @(posedge clk);
    w  = int'(write_wid);
    ok = write_enable && (write_addr == 12'hCC0 || write_addr == 12'hCC1) && (w < NW);
    if (reset) begin
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < NW; i++)
          for (int l = 0; l < NT; l++) m_scr[s][i][l] = '0;
      for (int i = 0; i < NW; i++) m_writes[i] = 0;
      m_cycles = 0;
      m_ill    = 1'b0;
      m_uuid   = '0;
    end else begin
      if (ok) begin
        for (int l = 0; l < NT; l++)
          if (write_tmask[l]) m_scr[(write_addr == 12'hCC1) ? 1 : 0][w][l] = write_data[l];
        m_writes[w]++;
      end
      m_ill = write_enable && !ok;
      if (m_ill) m_uuid = write_uuid;
      m_cycles++;
    end
    #1;
    if (check_ill) begin
      chk("illegal_write", 128'(illegal_write), 128'(m_ill));
      chk("illegal_uuid", 128'(illegal_uuid), 128'(m_uuid));
    end
    @(negedge clk);
  endtask

  task automatic rand_step();
    logic [NT-1:0][31:0] d;
    for (int l = 0; l < NT; l++) d[l] = $urandom;
    set_rd($urandom_range(0, 3) != 0, addr_pool[$urandom_range(0, 8)],
           $urandom_range(0, 5), NT'($urandom));
    if ($urandom_range(0, 3) == 0)
      set_wr(1'b1, addr_pool[$urandom_range(0, 8)], $urandom_range(0, 5), NT'($urandom), d, UB'($urandom));
    else
      set_wr($urandom_range(0, 1) == 1, 12'hCC0 + 12'($urandom_range(0, 1)),
             $urandom_range(0, 4), NT'($urandom), d, UB'($urandom));
    tick(1'b1, 1'b1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired before end of run");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] A = 32'hAAAA0001;
  localparam logic [31:0] B = 32'hBBBB0002;
  localparam logic [31:0] C = 32'hCCCC0003;
  localparam logic [31:0] D = 32'hDDDD0004;

  initial begin
    logic [NT-1:0][31:0] d;
    reset = 1'b1;
    set_rd(1'b0, 12'hCC0, 0, '0);
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    @(negedge clk);
    repeat (3) tick(1'b1, 1'b1);
    reset = 1'b0;

    // Reset state and first cycle counts
    set_rd(1'b1, 12'hCC8, 0, 4'hF);
    #1 chk("cycle_after_reset", read_data, '0);
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC8, 0, 4'hF);
    #1 chk("cycle_second", read_data, {4{32'd1}});
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC1, 3, 4'hF);
    tick(1'b1, 1'b1);

    // Lane-masked scratch write
    set_rd(1'b0, 12'hCC0, 1, 4'hF);
    set_wr(1'b1, 12'hCC0, 1, 4'b0101, {D, C, B, A}, 8'h11);
    tick(1'b1, 1'b1);
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    set_rd(1'b1, 12'hCC0, 1, 4'hF);
    #1 chk("scratch_masked", read_data, {32'h0, C, 32'h0, A});
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC6, 1, 4'hF);
    #1 chk("wrcnt_one", read_data, {4{32'd1}});
    tick(1'b1, 1'b1);

    // Same-cycle read sees the old value
    d = '0;
    d[0] = 32'h1234;
    set_wr(1'b1, 12'hCC1, 0, 4'b0001, d, 8'h22);
    set_rd(1'b1, 12'hCC1, 0, 4'b0001);
    #1 chk("no_bypass", read_data, '0);
    tick(1'b1, 1'b1);
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    #1 chk("after_write", read_data, {96'h0, 32'h1234});
    tick(1'b1, 1'b1);

    // Write to a read-only CSR is rejected for exactly one cycle
    set_wr(1'b1, 12'hCC8, 1, 4'hF, {4{32'hFFFF_FFFF}}, 8'd7);
    set_rd(1'b1, 12'hCC8, 0, 4'hF);
    tick(1'b1, 1'b0);
    #0 chk("illegal_pulse", 128'(illegal_write), 128'(1));
    chk("illegal_uuid7", 128'(illegal_uuid), 128'(7));
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    set_rd(1'b1, 12'hCC6, 1, 4'hF);
    #1 chk("wrcnt_unchanged", read_data, {4{32'd1}});
    tick(1'b1, 1'b1);
    chk("illegal_one_cycle", 128'(illegal_write), 128'(0));
    set_rd(1'b1, 12'hCC8, 0, 4'hF);
    tick(1'b1, 1'b1);

    // Identity reads, unmapped address, out-of-range warp
    set_rd(1'b1, 12'hCC4, 0, 4'hF);
    #1 chk("tid", read_data, {32'd3, 32'd2, 32'd1, 32'd0});
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC5, 3, 4'hF);
    #1 chk("wid3", read_data, {4{32'd3}});
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'h123, 2, 4'hF);
    #1 chk("unmapped", read_data, '0);
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC5, 5, 4'hF);
    set_wr(1'b1, 12'hCC0, 6, 4'hF, {4{32'h5555_5555}}, 8'h3C);
    #1 chk("wid_out_of_range", read_data, '0);
    tick(1'b1, 1'b1);
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);

    repeat (600) rand_step();

    // Saturating write counter after a clean reset
    reset = 1'b1;
    set_rd(1'b0, 12'hCC0, 0, '0);
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    tick(1'b1, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      for (int l = 0; l < NT; l++) d[l] = $urandom;
      set_wr(1'b1, 12'hCC0 + 12'(i & 1), 2, NT'($urandom), d, UB'($urandom));
      tick(1'b0, 1'b0);
    end
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    set_rd(1'b1, 12'hCC6, 2, 4'hF);
    #1 chk("wrcnt_sat", read_data, {4{32'h0000FFFF}});
    tick(1'b1, 1'b1);
    for (int w = 0; w < NW; w++) begin
      if (w != 2) begin
        set_rd(1'b1, 12'hCC6, w, 4'hF);
        #1 chk("wrcnt_other", read_data, '0);
        tick(1'b1, 1'b1);
      end
    end
    set_rd(1'b1, 12'hCC9, 0, 4'hF);
    tick(1'b1, 1'b1);

    // Reset mid-stream with a write pending
    repeat (20) rand_step();
    reset = 1'b1;
    set_wr(1'b1, 12'hCC0, 0, 4'hF, {4{32'hDEAD_BEEF}}, 8'h99);
    set_rd(1'b1, 12'hCC0, 0, 4'hF);
    tick(1'b1, 1'b1);
    reset = 1'b0;
    set_wr(1'b0, 12'hCC0, 0, '0, '0, '0);
    set_rd(1'b1, 12'hCC8, 0, 4'hF);
    #1 chk("post_reset_cycle0", read_data, '0);
    tick(1'b1, 1'b1);
    chk("no_illegal_in_reset", 128'(illegal_write), 128'(0));
    #1 chk("post_reset_cycle1", read_data, {4{32'd1}});
    tick(1'b1, 1'b1);
    set_rd(1'b1, 12'hCC0, 0, 4'hF);
    #1 chk("post_reset_scratch", read_data, '0);
    tick(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
